// File: rtl/mouse_click_detect_pkg.sv
// Shared constants for the mouse click conditioning block (65 MHz pclk defaults).
package mouse_click_detect_pkg;

   // Stable synced samples needed before a button level change is accepted
   localparam int DEBOUNCE_CYCLES_DEF = 32'd4;
   // Max release-to-press gap for a double click, about 0.4 s at 65 MHz
   localparam int DCLICK_CYCLES_DEF   = 32'd26_000_000;
   // Width of the mouse cursor coordinates
   localparam int COORD_W             = 32'd12;

endpackage

// File: rtl/mouse_click_detect_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the pclk domain.
module sync_2ff (
   input  logic pclk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1_r;
   logic s2_r;

   // Capture the asynchronous input and let the first stage settle for one cycle
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= d;
         s2_r <= s1_r;
      end
   end

   assign q = s2_r;

endmodule

// File: rtl/mouse_click_detect.sv
// Debounces the raw left mouse button, emits press/release/double-click pulses
// and latches the cursor position at each accepted press.
module mouse_click_detect
   import mouse_click_detect_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int DCLICK_CYCLES   = DCLICK_CYCLES_DEF
) (
   input  logic               pclk,
   input  logic               rst_n,
   input  logic               mouse_left_raw,
   input  logic [COORD_W-1:0] mouse_xpos,
   input  logic [COORD_W-1:0] mouse_ypos,
   output logic               mouse_left,
   output logic               press_pulse,
   output logic               release_pulse,
   output logic               double_click,
   output logic [COORD_W-1:0] click_xpos,
   output logic [COORD_W-1:0] click_ypos
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int GAP_W = $clog2(DCLICK_CYCLES);

   localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1'b1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 32'sd1);
   localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DCLICK_CYCLES - 32'sd1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DB_PRESS = 2'd1,
      ST_HELD     = 2'd2,
      ST_DB_REL   = 2'd3
   } state_e;

   logic             raw_sync_s;
   state_e           state_r;
   state_e           state_nxt_s;
   logic [DB_W-1:0]  cnt_r;
   logic [DB_W-1:0]  cnt_nxt_s;
   logic             press_evt_s;
   logic             release_evt_s;

   logic             mouse_left_r;
   logic             press_pulse_r;
   logic             release_pulse_r;
   logic             double_click_r;
   logic [COORD_W-1:0] click_xpos_r;
   logic [COORD_W-1:0] click_ypos_r;

   logic [GAP_W-1:0] gap_cnt_r;
   logic             armed_r;
   logic             dbl_seen_r;

   sync_2ff u_sync (
      .pclk  (pclk),
      .rst_n (rst_n),
      .d     (mouse_left_raw),
      .q     (raw_sync_s)
   );

   // Debounce state and stability counter registers
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Debounce next-state logic; a level change is accepted only after it stays stable
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      press_evt_s   = 1'b0;
      release_evt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (raw_sync_s) begin
               state_nxt_s = ST_DB_PRESS;
               cnt_nxt_s   = DB_ONE;
            end else begin
               cnt_nxt_s   = '0;
            end
         end
         ST_DB_PRESS: begin
            if (!raw_sync_s) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = '0;
            end else if (cnt_r == DB_LAST) begin
               state_nxt_s = ST_HELD;
               cnt_nxt_s   = '0;
               press_evt_s = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + DB_ONE;
            end
         end
         ST_HELD: begin
            if (!raw_sync_s) begin
               state_nxt_s = ST_DB_REL;
               cnt_nxt_s   = DB_ONE;
            end else begin
               cnt_nxt_s   = '0;
            end
         end
         ST_DB_REL: begin
            if (raw_sync_s) begin
               state_nxt_s   = ST_HELD;
               cnt_nxt_s     = '0;
            end else if (cnt_r == DB_LAST) begin
               state_nxt_s   = ST_IDLE;
               cnt_nxt_s     = '0;
               release_evt_s = 1'b1;
            end else begin
               cnt_nxt_s     = cnt_r + DB_ONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Registered level, event pulses and press-position capture
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         mouse_left_r    <= 1'b0;
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
         double_click_r  <= 1'b0;
         click_xpos_r    <= '0;
         click_ypos_r    <= '0;
      end else begin
         press_pulse_r   <= press_evt_s;
         release_pulse_r <= release_evt_s;
         double_click_r  <= press_evt_s & armed_r;
         if (press_evt_s) begin
            mouse_left_r <= 1'b1;
            click_xpos_r <= mouse_xpos;
            click_ypos_r <= mouse_ypos;
         end else if (release_evt_s) begin
            mouse_left_r <= 1'b0;
         end else begin
            mouse_left_r <= mouse_left_r;
         end
      end
   end

   // Release-to-press gap window; the release that ends a double click does not
   // re-arm it, so a third quick click starts a fresh pair
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt_r  <= '0;
         armed_r    <= 1'b0;
         dbl_seen_r <= 1'b0;
      end else if (press_evt_s) begin
         armed_r    <= 1'b0;
         dbl_seen_r <= armed_r;
      end else if (release_evt_s) begin
         gap_cnt_r  <= '0;
         armed_r    <= ~dbl_seen_r;
         dbl_seen_r <= 1'b0;
      end else if (armed_r) begin
         if (gap_cnt_r == GAP_LAST) begin
            armed_r   <= 1'b0;
         end else begin
            gap_cnt_r <= gap_cnt_r + GAP_ONE;
         end
      end else begin
         gap_cnt_r <= gap_cnt_r;
      end
   end

   assign mouse_left    = mouse_left_r;
   assign press_pulse   = press_pulse_r;
   assign release_pulse = release_pulse_r;
   assign double_click  = double_click_r;
   assign click_xpos    = click_xpos_r;
   assign click_ypos    = click_ypos_r;

endmodule
